// File: rtl/reg_dump_printer_pkg.sv
// rtl/reg_dump_printer_pkg.sv - shared text-buffer geometry, ASCII constants and dump FSM states
//
// Purpose: constants common to the register dump engine, the VGA text
//          controller and the core's memory-mapped store path.
// Ports:   none (package).
package reg_dump_printer_pkg;

  // Text-buffer geometry shared with the VGA controller and the store path.
  localparam int TXT_COLS   = 80;
  localparam int TXT_ADDR_W = 13;
  localparam int TXT_DEPTH  = 1 << TXT_ADDR_W;

  localparam logic [23:0] ATTR_DEFAULT = 24'hFFFFFF;

  localparam logic [7:0] ASCII_X     = 8'h78;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;

  localparam logic [4:0] LAST_REG = 5'd31;
  localparam logic [3:0] LAST_COL = 4'd12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_EMIT,
    ST_DONE
  } dump_state_t;

  // Decimal split of a register index 0..31 by comparison, avoiding a divider.
  function automatic logic [1:0] dec_tens(input logic [4:0] idx);
    if (idx >= 5'd30)      return 2'd3;
    else if (idx >= 5'd20) return 2'd2;
    else if (idx >= 5'd10) return 2'd1;
    else                   return 2'd0;
  endfunction

  // units = idx - 10*tens, with 10*tens built from shifts (8*t + 2*t).
  function automatic logic [3:0] dec_units(input logic [4:0] idx);
    logic [1:0] t;
    logic [4:0] ten_t;
    t     = dec_tens(idx);
    ten_t = {t, 3'b000} + {2'b00, t, 1'b0};
    return 4'(idx - ten_t);
  endfunction

endpackage

// File: rtl/reg_dump_printer_if.sv
// rtl/reg_dump_printer_if.sv - debug read port and text-buffer write port bundle
//
// Purpose: groups the register-file debug port and the character write
//          handshake used by the dump engine.
// Signals: wr_valid/wr_ready/wr_addr/wr_data - character write request;
//          debug_addr/debug_data               - register-file debug read.
// Modports: master = dump engine, slave = register file + text buffer side.
interface reg_dump_printer_if;
  import reg_dump_printer_pkg::*;

  logic                  wr_valid;
  logic                  wr_ready;
  logic [TXT_ADDR_W-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [4:0]            debug_addr;
  logic [31:0]           debug_data;

  modport master (
    output wr_valid, wr_addr, wr_data, debug_addr,
    input  wr_ready, debug_data
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, debug_addr,
    output wr_ready, debug_data
  );

endinterface

// File: rtl/reg_dump_printer_nibble_to_ascii.sv
// rtl/reg_dump_printer_nibble_to_ascii.sv - combinational 4-bit to uppercase hex ASCII encoder
//
// Purpose: maps 0-9 to '0'-'9' and 10-15 to 'A'-'F'. Also serves decimal
//          digits, since a digit 0-9 is just a small nibble.
// Ports:   i_nibble - 4-bit value; o_ascii - 8-bit ASCII character.
module nibble_to_ascii
  import reg_dump_printer_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_ascii
);

  always_comb begin
    o_ascii = ASCII_0;
    if (i_nibble < 4'd10) o_ascii = ASCII_0 + {4'd0, i_nibble};
    else                  o_ascii = ASCII_A + {4'd0, i_nibble - 4'd10};
  end

endmodule

// File: rtl/reg_dump_printer.sv
// rtl/reg_dump_printer.sv - walks x0..x31 and prints "xNN: HHHHHHHH" lines into the text buffer
//
// Purpose: on i_start, reads each register through the debug port and writes
//          one 13-character line per register, row BASE_ROW+N for xN.
// Ports:   clk, rst (async, active-low);
//          i_start - begin a dump (only honoured in IDLE);
//          o_busy  - high from the cycle after acceptance through DONE;
//          o_done  - one-cycle completion pulse;
//          bus     - debug read port and character write handshake (master).
module reg_dump_printer
  import reg_dump_printer_pkg::*;
#(
  parameter int          BASE_ROW = 0,
  parameter int          COLS     = TXT_COLS,
  parameter logic [23:0] ATTR     = ATTR_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  output logic                      o_busy,
  output logic                      o_done,
  reg_dump_printer_if.master        bus
);

  // The last character of x31 must still fit in the 13-bit buffer address.
  if ((BASE_ROW + int'(LAST_REG)) * COLS + int'(LAST_COL) >= TXT_DEPTH) begin : g_bad_geometry
    $error("reg_dump_printer: BASE_ROW/COLS place x31 outside the text buffer");
  end

  dump_state_t           r_state;
  logic [4:0]            r_reg_idx;
  logic [3:0]            r_col;
  logic [31:0]           r_word;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_wr_valid;
  logic [TXT_ADDR_W-1:0] r_wr_addr;
  logic [31:0]           r_wr_data;

  logic                  w_hs;
  logic [3:0]            w_next_col;
  logic [2:0]            w_nib_sel;
  logic [3:0]            w_nibble;
  logic [7:0]            w_hex_char;
  logic [7:0]            w_char;
  logic [TXT_ADDR_W-1:0] w_row;
  logic [TXT_ADDR_W-1:0] w_addr;

  assign w_hs = r_wr_valid & bus.wr_ready;

  // Outputs are registered, so the character for the column about to be
  // presented is built one cycle ahead: col 0 when leaving CAPTURE, col+1
  // on each accepted write.
  assign w_next_col = (r_state == ST_CAPTURE) ? 4'd0 : r_col + 4'd1;

  // Word nibble index: col 5 -> word[31:28] ... col 12 -> word[3:0].
  assign w_nib_sel = 3'(LAST_COL - w_next_col);

  always_comb begin
    w_nibble = r_word[{w_nib_sel, 2'b00} +: 4];
    if (w_next_col == 4'd1)      w_nibble = {2'b00, dec_tens(r_reg_idx)};
    else if (w_next_col == 4'd2) w_nibble = dec_units(r_reg_idx);
  end

  nibble_to_ascii u_hex (
    .i_nibble (w_nibble),
    .o_ascii  (w_hex_char)
  );

  always_comb begin
    w_char = w_hex_char;
    case (w_next_col)
      4'd0:    w_char = ASCII_X;
      4'd3:    w_char = ASCII_COLON;
      4'd4:    w_char = ASCII_SPACE;
      default: w_char = w_hex_char;
    endcase
  end

  assign w_row  = TXT_ADDR_W'(BASE_ROW) + TXT_ADDR_W'(r_reg_idx);
  assign w_addr = w_row * TXT_ADDR_W'(COLS) + TXT_ADDR_W'(w_next_col);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_reg_idx  <= '0;
      r_col      <= '0;
      r_word     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state   <= ST_READ;
            r_reg_idx <= '0;
            r_busy    <= 1'b1;
          end
        end
        // debug_addr already shows r_reg_idx; READ gives the port its cycle.
        ST_READ: r_state <= ST_CAPTURE;
        ST_CAPTURE: begin
          r_word     <= bus.debug_data;
          r_col      <= '0;
          r_wr_valid <= 1'b1;
          r_wr_addr  <= w_addr;
          r_wr_data  <= {w_char, ATTR};
          r_state    <= ST_EMIT;
        end
        ST_EMIT: begin
          if (w_hs) begin
            if (r_col != LAST_COL) begin
              r_col     <= w_next_col;
              r_wr_addr <= w_addr;
              r_wr_data <= {w_char, ATTR};
            end else begin
              r_wr_valid <= 1'b0;
              if (r_reg_idx != LAST_REG) begin
                r_reg_idx <= r_reg_idx + 5'd1;
                r_state   <= ST_READ;
              end else begin
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign bus.wr_valid   = r_wr_valid;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.debug_addr = r_reg_idx;

endmodule

// File: tb/tb_reg_dump_printer.sv
// tb/tb_reg_dump_printer.sv - scoreboard bench for reg_dump_printer at BASE_ROW 0 and 2
module tb_reg_dump_printer;
  import reg_dump_printer_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       wr_ready = 1'b1;
  logic [1:0] busy;
  logic [1:0] done;
  logic [31:0] regs [32];

  reg_dump_printer_if bus0 ();
  reg_dump_printer_if bus2 ();

  assign bus0.wr_ready   = wr_ready;
  assign bus2.wr_ready   = wr_ready;
  assign bus0.debug_data = regs[bus0.debug_addr];
  assign bus2.debug_data = regs[bus2.debug_addr];

  reg_dump_printer #(.BASE_ROW(0)) dut0 (
    .clk(clk), .rst(rst), .i_start(start), .o_busy(busy[0]), .o_done(done[0]), .bus(bus0)
  );
  reg_dump_printer #(.BASE_ROW(2)) dut2 (
    .clk(clk), .rst(rst), .i_start(start), .o_busy(busy[1]), .o_done(done[1]), .bus(bus2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [44:0] exp_q [2][$];
  int hs_cnt [2];
  int done_cnt [2];
  bit stalled [2];
  logic [44:0] stall_snap [2];
  int stall_cnt = 0;
  int first_valid_cyc = -1;
  bit rand_ready = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference: each line is the text "xNN: HHHHHHHH" at row base+N, cols 0..12.
  function automatic void push_expect(int d, int base);
    string hexd;
    string s;
    logic [12:0] a;
    logic [3:0] nib;
    hexd = "0123456789ABCDEF";
    for (int r = 0; r < 32; r++) begin
      s = $sformatf("x%02d: ", r);
      for (int n = 7; n >= 0; n--) begin
        nib = regs[r][n*4 +: 4];
        s = {s, hexd.substr(int'(nib), int'(nib))};
      end
      for (int c = 0; c < 13; c++) begin
        a = 13'((base + r) * 80 + c);
        exp_q[d].push_back({a, s[c], 24'hFFFFFF});
      end
    end
  endfunction

  function automatic void mon(int d, logic v, logic [12:0] a, logic [31:0] dat, logic dn);
    logic [44:0] cur;
    logic [44:0] e;
    cur = {a, dat};
    if (stalled[d]) begin
      chk($sformatf("stall_valid_d%0d", d), 64'(v), 64'd1);
      chk($sformatf("stall_hold_d%0d", d), 64'(cur), 64'(stall_snap[d]));
    end
    stalled[d] = 1'b0;
    if (v && wr_ready) begin
      if (exp_q[d].size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write_d%0d: got %0h expected none", d, cur);
      end else begin
        e = exp_q[d].pop_front();
        chk($sformatf("write_d%0d_n%0d", d, hs_cnt[d]), 64'(cur), 64'(e));
      end
      hs_cnt[d]++;
    end else if (v) begin
      stalled[d] = 1'b1;
      stall_snap[d] = cur;
      if (d == 0) stall_cnt++;
    end
    if (d == 0 && v && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (dn) done_cnt[d]++;
  endfunction

  // Monitor: owns wr_ready so the handshake it scores is the one the DUT sees.
  initial begin
    forever begin
      @(negedge clk);
      wr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!rst) begin
        stalled[0] = 1'b0;
        stalled[1] = 1'b0;
      end else begin
        mon(0, bus0.wr_valid, bus0.wr_addr, bus0.wr_data, done[0]);
        mon(1, bus2.wr_valid, bus2.wr_addr, bus2.wr_data, done[1]);
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_dump(input bit flip, input bit extra_start, input string tag);
    int e0, hs_b0, hs_b1, dn_b0, dn_b1, done_at, stalls;
    bit flipped, seen;
    logic [31:0] saved;
    flipped = 1'b0;
    seen = 1'b0;
    done_at = 0;
    stalls = 0;
    push_expect(0, 0);
    push_expect(1, 2);
    hs_b0 = hs_cnt[0];
    hs_b1 = hs_cnt[1];
    dn_b0 = done_cnt[0];
    dn_b1 = done_cnt[1];
    stall_cnt = 0;
    first_valid_cyc = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    e0 = cyc;
    chk({tag, "_busy_after_start"}, 64'(busy), 64'h3);
    for (int k = 0; k < 4000 && !seen; k++) begin
      if (done[0]) begin
        seen = 1'b1;
        done_at = cyc;
        stalls = stall_cnt;
      end else begin
        // Alter x3 after it was captured: the printed line must not change.
        if (flip && !flipped && bus0.wr_valid && bus0.wr_addr == 13'd245) begin
          saved = regs[3];
          regs[3] = ~saved;
          flipped = 1'b1;
        end
        if (extra_start) start = (k == 100);
        tick();
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (extra_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk({tag, "_first_valid_cycle"}, 64'(first_valid_cyc - e0), 64'd2);
    chk({tag, "_done_cycle"}, 64'(done_at - e0), 64'(480 + stalls));
    if (flip) chk({tag, "_flip_happened"}, 64'(flipped), 64'd1);
    tick(40);
    chk({tag, "_hs_count_d0"}, 64'(hs_cnt[0] - hs_b0), 64'd416);
    chk({tag, "_hs_count_d2"}, 64'(hs_cnt[1] - hs_b1), 64'd416);
    chk({tag, "_done_count_d0"}, 64'(done_cnt[0] - dn_b0), 64'd1);
    chk({tag, "_done_count_d2"}, 64'(done_cnt[1] - dn_b1), 64'd1);
    chk({tag, "_queue_drained"}, 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_idle_valid"}, 64'({bus0.wr_valid, bus2.wr_valid}), 64'd0);
  endtask

  initial begin
    bit hit;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    rst = 1'b0;
    tick(3);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_valid", 64'({bus0.wr_valid, bus2.wr_valid}), 64'd0);
    chk("reset_addr", 64'(bus0.wr_addr), 64'd0);
    chk("reset_data", 64'(bus0.wr_data), 64'd0);
    chk("reset_debug_addr", 64'(bus0.debug_addr), 64'd0);
    rst = 1'b1;
    tick(2);

    // Full-rate dump with known corner words.
    regs[0]  = 32'h0;
    regs[5]  = 32'hDEADBEEF;
    regs[31] = 32'h0000000F;
    regs[10] = 32'h0123ABCD;
    rand_ready = 1'b0;
    run_dump(1'b0, 1'b0, "full_rate");

    // Random back-pressure plus a post-capture change of x3.
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    rand_ready = 1'b1;
    run_dump(1'b1, 1'b0, "stall_flip");

    // Start pulsed while busy and in DONE must not queue a second dump.
    rand_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    run_dump(1'b0, 1'b1, "extra_start");

    // Reset at x7 col 6, then a clean dump from x0.
    rand_ready = 1'b1;
    push_expect(0, 0);
    push_expect(1, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 4000 && !hit; k++) begin
      if (bus0.wr_valid && bus0.wr_addr == 13'd566) hit = 1'b1;
      else tick();
    end
    chk("mid_reset_reached", 64'(hit), 64'd1);
    rst = 1'b0;
    #1;
    chk("mid_reset_valid", 64'({bus0.wr_valid, bus2.wr_valid}), 64'd0);
    chk("mid_reset_busy", 64'(busy), 64'd0);
    chk("mid_reset_debug_addr", 64'(bus0.debug_addr), 64'd0);
    exp_q[0].delete();
    exp_q[1].delete();
    tick(2);
    rst = 1'b1;
    tick(2);
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    run_dump(1'b0, 1'b0, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
